// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI slave endpoint, oversampled in the clk domain.
// It supports all four CPOL/CPHA modes and moves data as MSB-first bytes.
// Ports:
//   clk, arst (sync, active-high)          system clock and reset
//   cpol, cpha                             SPI mode, latched at frame start
//   cs, sclk, mosi                         asynchronous SPI inputs
//   miso, miso_oe                          registered SPI output and its enable
//   tx_data, tx_load, tx_ready             single-entry TX buffer handshake
//   tx_underrun                            pulse: a byte slot started with no TX byte
//   rx_data, rx_valid                      last received byte and its update pulse
//   frame_err                              pulse: cs rose mid-byte
//   busy                                   frame active
module spi_slave_if #(
   parameter int unsigned       DATA_W      = 8,
   parameter int unsigned       SYNC_STAGES = 2,
   parameter logic [DATA_W-1:0] TX_IDLE     = '0
) (
   input  logic              clk,
   input  logic              arst,
   input  logic              cpol,
   input  logic              cpha,
   input  logic              cs,
   input  logic              sclk,
   input  logic              mosi,
   output logic              miso,
   output logic              miso_oe,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_load,
   output logic              tx_ready,
   output logic              tx_underrun,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              frame_err,
   output logic              busy
);

   localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

   state_t state, state_n;

   logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, mosi_sync;
   logic                   cs_d, sclk_d;
   logic [SYNC_STAGES:0]   settle;
   logic                   armed;
   logic                   cpol_q, cpha_q;
   logic                   start_q;
   logic [CNT_W-1:0]       bit_cnt;
   logic [DATA_W-1:0]      rx_sh, tx_sh, tx_buf;

   logic cs_s, sclk_s, mosi_s;
   logic cs_fall, cs_rise, lead, trail;
   logic start, stop, sample, drive, wrap, reload;

   assign cs_s    = cs_sync[SYNC_STAGES-1];
   assign sclk_s  = sclk_sync[SYNC_STAGES-1];
   assign mosi_s  = mosi_sync[SYNC_STAGES-1];
   // a falling cs only counts once cs has been seen high since reset
   assign cs_fall = armed & cs_d & ~cs_s;
   assign cs_rise = ~cs_d & cs_s;
   assign lead    = (sclk_d == cpol_q) & (sclk_s != cpol_q);
   assign trail   = (sclk_d != cpol_q) & (sclk_s == cpol_q);

   // synchronizers, edge history and post-reset arming
   always_ff @(posedge clk) begin
      if (arst) begin
         cs_sync   <= '1;
         sclk_sync <= '0;
         mosi_sync <= '0;
         cs_d      <= 1'b1;
         sclk_d    <= 1'b0;
         settle    <= '0;
         armed     <= 1'b0;
      end else begin
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
         cs_d      <= cs_s;
         sclk_d    <= sclk_s;
         settle    <= {settle[SYNC_STAGES-1:0], 1'b1};
         // settle covers the time until the chain holds only real samples
         armed     <= armed | (settle[SYNC_STAGES] & cs_s & cs_d);
      end
   end

   // state register
   always_ff @(posedge clk) begin
      if (arst) state <= IDLE;
      else      state <= state_n;
   end

   // next state and per-cycle control strobes
   always_comb begin
      state_n = state;
      start   = 1'b0;
      stop    = 1'b0;
      sample  = 1'b0;
      drive   = 1'b0;
      case (state)
         IDLE: begin
            if (cs_fall) begin
               state_n = ACTIVE;
               start   = 1'b1;
            end
         end
         ACTIVE: begin
            if (cs_rise) begin
               state_n = IDLE;
               stop    = 1'b1;
            end else begin
               sample = cpha_q ? trail : lead;
               drive  = cpha_q ? lead  : trail;
            end
         end
         default: state_n = IDLE;
      endcase
      wrap   = sample && (bit_cnt == LAST_BIT);
      reload = start || wrap;
   end

   // datapath: shift registers, TX buffer, registered outputs
   always_ff @(posedge clk) begin
      if (arst) begin
         cpol_q      <= 1'b0;
         cpha_q      <= 1'b0;
         start_q     <= 1'b0;
         bit_cnt     <= '0;
         rx_sh       <= '0;
         tx_sh       <= '0;
         tx_buf      <= '0;
         tx_ready    <= 1'b1;
         miso        <= 1'b0;
         miso_oe     <= 1'b0;
         busy        <= 1'b0;
         rx_data     <= '0;
         rx_valid    <= 1'b0;
         tx_underrun <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         rx_valid    <= 1'b0;
         tx_underrun <= 1'b0;
         frame_err   <= 1'b0;
         busy        <= (state_n == ACTIVE);
         miso_oe     <= (state_n == ACTIVE);
         start_q     <= start;

         if (start) begin
            cpol_q  <= cpol;
            cpha_q  <= cpha;
            bit_cnt <= '0;
            rx_sh   <= '0;
         end

         if (sample) begin
            rx_sh   <= {rx_sh[DATA_W-2:0], mosi_s};
            bit_cnt <= wrap ? '0 : bit_cnt + CNT_W'(1);
         end

         if (wrap) begin
            rx_data  <= {rx_sh[DATA_W-2:0], mosi_s};
            rx_valid <= 1'b1;
         end

         // the partial byte is dropped on an early cs release
         if (stop) begin
            if (bit_cnt != '0) frame_err <= 1'b1;
            bit_cnt <= '0;
            rx_sh   <= '0;
         end

         // the reload consumes the old buffer before any same-cycle load
         if (reload) begin
            if (!tx_ready) begin
               tx_sh    <= tx_buf;
               tx_ready <= 1'b1;
            end else begin
               tx_sh       <= TX_IDLE;
               tx_underrun <= 1'b1;
            end
         end else if (drive) begin
            // cpha=0 drive edge right after a reload presents the new MSB unshifted
            if (cpha_q || (bit_cnt != '0)) tx_sh <= tx_sh << 1;
         end

         if (tx_load && tx_ready) begin
            tx_buf   <= tx_data;
            tx_ready <= 1'b0;
         end

         if (state_n == IDLE) begin
            miso <= 1'b0;
         end else if (drive) begin
            if (cpha_q || (bit_cnt == '0)) miso <= tx_sh[DATA_W-1];
            else                           miso <= tx_sh[DATA_W-2];
         end else if (start_q && !cpha_q) begin
            miso <= tx_sh[DATA_W-1];
         end
      end
   end

endmodule

// File: tb/tb_spi_slave_if.sv
// tb_spi_slave_if: bit-level SPI master model driving spi_slave_if.
// Received bytes are checked through a scoreboard queue. Mode vectors come from a table.
`timescale 1ns/1ps
module tb_spi_slave_if;

   localparam int unsigned H     = 8;   // clk periods per SCLK half cycle
   localparam int unsigned SETUP = 8;   // clk periods from cs fall to first edge

   logic       clk, arst, cpol, cpha, cs, sclk, mosi;
   logic       miso, miso_oe, tx_load, tx_ready, tx_underrun;
   logic       rx_valid, frame_err, busy;
   logic [7:0] tx_data, rx_data;

   int total = 0;
   int bad   = 0;
   int fe_cnt  = 0;
   int und_cnt = 0;
   int rxv_cnt = 0;
   logic [7:0] sb[$];

   spi_slave_if dut (
      .clk(clk), .arst(arst), .cpol(cpol), .cpha(cpha), .cs(cs), .sclk(sclk),
      .mosi(mosi), .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data),
      .tx_load(tx_load), .tx_ready(tx_ready), .tx_underrun(tx_underrun),
      .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
      end
   endtask

   task automatic wclk(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   // scoreboard and pulse counters
   always @(negedge clk) begin
      if (!arst) begin
         if (frame_err)   fe_cnt++;
         if (tx_underrun) und_cnt++;
         if (rx_valid) begin
            rxv_cnt++;
            total++;
            if (sb.size() == 0) begin
               bad++;
               $display("FAIL rx_unexpected act=%0h exp=none", rx_data);
            end else begin
               logic [7:0] e;
               e = sb.pop_front();
               if (rx_data !== e) begin
                  bad++;
                  $display("FAIL rx_data act=%0h exp=%0h", rx_data, e);
               end
            end
         end
      end
   end

   task automatic load_tx(input logic [7:0] b);
      int n;
      n = 0;
      while (!tx_ready && n < 100) begin wclk(1); n++; end
      chk("load_ready", 32'(tx_ready), 32'd1);
      tx_data = b;
      tx_load = 1'b1;
      wclk(1);
      tx_load = 1'b0;
      chk("load_ready_low", 32'(tx_ready), 32'd0);
   endtask

   task automatic sb_drain(input string nm);
      int n;
      n = 0;
      while (sb.size() != 0 && n < 60) begin wclk(1); n++; end
      chk(nm, 32'(sb.size()), 32'd0);
   endtask

   // master: clocks nbits bits of mo (MSB first); got collects miso
   task automatic spi_xfer(input logic pol, input logic pha, input logic [15:0] mo_in,
                           input int nbits, input bit raise_cs,
                           output logic [15:0] got, output logic rdy_start,
                           output int und_start);
      logic [15:0] mo;
      int          und0;
      mo   = mo_in;
      got  = '0;
      cpol = pol;
      cpha = pha;
      sclk = pol;
      wclk(6);
      und0 = und_cnt;
      cs = 1'b0;
      if (!pha) mosi = mo[15];
      wclk(SETUP);
      rdy_start = tx_ready;
      und_start = und_cnt - und0;
      for (int i = 0; i < nbits; i++) begin
         if (!pha) begin
            sclk = ~pol;
            got  = {got[14:0], miso};
            wclk(H);
            sclk = pol;
            mo   = mo << 1;
            mosi = mo[15];
            wclk(H);
         end else begin
            sclk = ~pol;
            mosi = mo[15];
            mo   = mo << 1;
            wclk(H);
            sclk = pol;
            got  = {got[14:0], miso};
            wclk(H);
         end
      end
      if (raise_cs) begin
         cs = 1'b1;
         wclk(8);
      end
   endtask

   typedef struct {
      logic       pol;
      logic       pha;
      logic [7:0] tx;
      logic [7:0] mo;
      logic [7:0] exp_rx;
      logic [7:0] exp_mi;
   } vec_t;

   vec_t        vecs[4];
   logic [15:0] got;
   logic        rdy;
   int          und_s, fe0, rxv0;

   initial begin
      vecs[0] = '{1'b0, 1'b0, 8'h3C, 8'hA5, 8'hA5, 8'h3C};
      vecs[1] = '{1'b1, 1'b1, 8'h81, 8'h5A, 8'h5A, 8'h81};
      vecs[2] = '{1'b0, 1'b1, 8'hC6, 8'h39, 8'h39, 8'hC6};
      vecs[3] = '{1'b1, 1'b0, 8'h0F, 8'hF0, 8'hF0, 8'h0F};

      arst = 1'b1; cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
      cpol = 1'b0; cpha = 1'b0; tx_load = 1'b0; tx_data = '0;
      wclk(3);
      chk("rst_miso", 32'(miso), 32'd0);
      chk("rst_miso_oe", 32'(miso_oe), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_tx_ready", 32'(tx_ready), 32'd1);
      chk("rst_rx_data", 32'(rx_data), 32'd0);
      chk("rst_rx_valid", 32'(rx_valid), 32'd0);
      chk("rst_underrun", 32'(tx_underrun), 32'd0);
      chk("rst_frame_err", 32'(frame_err), 32'd0);
      arst = 1'b0;
      wclk(8);

      // single-byte frames in all four modes
      for (int i = 0; i < 4; i++) begin
         fe0 = fe_cnt;
         load_tx(vecs[i].tx);
         sb.push_back(vecs[i].exp_rx);
         spi_xfer(vecs[i].pol, vecs[i].pha, {vecs[i].mo, 8'h00}, 8, 1'b1, got, rdy, und_s);
         sb_drain($sformatf("v%0d_rx_seen", i));
         chk($sformatf("v%0d_miso_byte", i), 32'(got[7:0]), 32'(vecs[i].exp_mi));
         chk($sformatf("v%0d_ready_at_start", i), 32'(rdy), 32'd1);
         chk($sformatf("v%0d_no_underrun_start", i), 32'(und_s), 32'd0);
         chk($sformatf("v%0d_no_frame_err", i), 32'(fe_cnt - fe0), 32'd0);
         chk($sformatf("v%0d_idle_oe", i), 32'({busy, miso_oe, miso}), 32'd0);
      end

      // two bytes in one frame; a load while full is ignored
      load_tx(8'hAA);
      tx_data = 8'hEE;
      tx_load = 1'b1;
      wclk(1);
      tx_load = 1'b0;
      rxv0 = rxv_cnt;
      sb.push_back(8'h12);
      sb.push_back(8'h34);
      fork
         spi_xfer(1'b0, 1'b0, 16'h1234, 16, 1'b1, got, rdy, und_s);
         begin
            wclk(40);
            load_tx(8'h55);
         end
      join
      sb_drain("two_rx_seen");
      chk("two_rx_count", 32'(rxv_cnt - rxv0), 32'd2);
      chk("two_miso", 32'(got), 32'hAA55);

      // underrun at frame start
      sb.push_back(8'h77);
      spi_xfer(1'b0, 1'b0, 16'h7700, 8, 1'b1, got, rdy, und_s);
      sb_drain("und_rx_seen");
      chk("und_at_start", 32'(und_s), 32'd1);
      chk("und_miso", 32'(got[7:0]), 32'h00);

      // abort after 3 SCLK cycles, then a good frame
      fe0  = fe_cnt;
      rxv0 = rxv_cnt;
      spi_xfer(1'b0, 1'b0, 16'hFF00, 3, 1'b1, got, rdy, und_s);
      chk("abort_frame_err", 32'(fe_cnt - fe0), 32'd1);
      chk("abort_no_rx", 32'(rxv_cnt - rxv0), 32'd0);
      chk("abort_idle", 32'({busy, miso_oe}), 32'd0);
      load_tx(8'h96);
      sb.push_back(8'h69);
      spi_xfer(1'b0, 1'b0, 16'h6900, 8, 1'b1, got, rdy, und_s);
      sb_drain("after_abort_rx");
      chk("after_abort_miso", 32'(got[7:0]), 32'h96);

      // reset mid-frame after bit 4
      load_tx(8'h5B);
      fe0  = fe_cnt;
      rxv0 = rxv_cnt;
      spi_xfer(1'b0, 1'b0, 16'hF000, 4, 1'b0, got, rdy, und_s);
      chk("pre_rst_busy", 32'(busy), 32'd1);
      arst = 1'b1;
      wclk(2);
      chk("mid_rst_outs", 32'({miso, miso_oe, busy, rx_valid, tx_underrun, frame_err}), 32'd0);
      chk("mid_rst_ready", 32'(tx_ready), 32'd1);
      arst = 1'b0;
      wclk(20);
      chk("post_rst_wait_fresh_cs", 32'(busy), 32'd0);
      chk("post_rst_no_pulses", 32'((fe_cnt - fe0) + (rxv_cnt - rxv0)), 32'd0);
      cs = 1'b1;
      sclk = 1'b0;
      wclk(8);
      load_tx(8'h3A);
      sb.push_back(8'hC3);
      spi_xfer(1'b0, 1'b0, 16'hC300, 8, 1'b1, got, rdy, und_s);
      sb_drain("post_rst_rx");
      chk("post_rst_miso", 32'(got[7:0]), 32'h3A);

      wclk(20);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
